// File: rtl/ahb_pkg.sv
// Purpose : shared AHB-Lite encodings (HTRANS/HBURST/HSIZE/HRESP), slave FSM states, byte-lane helper.
// Latency : n/a (types and a pure function only).
// Backpres: n/a.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    // Codes not listed here are treated as undefined-length INCR.
    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011
    } hburst_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'b000,
        HSIZE_HALF = 3'b001,
        HSIZE_WORD = 3'b010
    } hsize_e;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_e;

    typedef enum logic [2:0] {
        SLV_IDLE = 3'd0,
        SLV_WAIT = 3'd1,
        SLV_DATA = 3'd2,
        SLV_ERR1 = 3'd3,
        SLV_ERR2 = 3'd4
    } slv_state_e;

    // Little-endian byte enables of a 32-bit word for an aligned transfer.
    function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] lane);
        case (size)
            HSIZE_BYTE: byte_en = 4'b0001 << lane;
            HSIZE_HALF: byte_en = lane[1] ? 4'b1100 : 4'b0011;
            default:    byte_en = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/ahb_slave_mem_if.sv
// Purpose : AHB-Lite master<->slave signal bundle with master/slave modports.
// Latency : n/a (wires only).
// Backpres: HREADY driven by the slave stretches the master's data phase.
// Ports   : HSEL/HADDR/HWRITE/HSIZE/HBURST/HTRANS/HWDATA from master; HREADY/HRESP/HRDATA from slave.
interface ahb_slave_mem_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              HSEL;
    logic [ADDR_W-1:0] HADDR;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [2:0]        HBURST;
    logic [1:0]        HTRANS;
    logic [DATA_W-1:0] HWDATA;
    logic              HREADY;
    logic              HRESP;
    logic [DATA_W-1:0] HRDATA;

    modport master (
        output HSEL, HADDR, HWRITE, HSIZE, HBURST, HTRANS, HWDATA,
        input  HREADY, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HWRITE, HSIZE, HBURST, HTRANS, HWDATA,
        output HREADY, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_slave_bytemem.sv
// Purpose : word array with per-byte write enables, storage behind the AHB slave.
// Latency : write commits at the clock edge; read is combinational from idx.
// Backpres: none, accepts a write every cycle.
// Ports   : CLK_SLAVE; wr_en/idx/be/wr_dat write side; rd_dat = mem[idx].
module ahb_slave_bytemem #(
    parameter int WORDS  = 64,
    parameter int DATA_W = 32,
    parameter int IDX_W  = $clog2(WORDS)
) (
    input  logic                CLK_SLAVE,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    idx,
    input  logic [DATA_W/8-1:0] be,
    input  logic [DATA_W-1:0]   wr_dat,
    output logic [DATA_W-1:0]   rd_dat
);
    // Contents intentionally survive reset.
    logic [DATA_W-1:0] mem [WORDS];

    always_ff @(posedge CLK_SLAVE) begin
        if (wr_en) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wr_dat[8*b +: 8];
            end
        end
    end

    assign rd_dat = mem[idx];
endmodule

// File: rtl/ahb_slave_mem.sv
// Purpose : AHB-Lite single-port memory responder with wait states and two-cycle ERROR response.
// Latency : data phase completes WAIT_CYCLES cycles after address accept; errors take 2 cycles.
// Backpres: HREADY low during wait states and ERR1; pipelined back-to-back transfers otherwise.
// Ports   : CLK_SLAVE, RESET_SLAVE (async active-low), bus (ahb_slave_mem_if.slave), burst_err.
// Option  : define AHB_SLV_BURST_CHECK_EN to enable the sticky SEQ-address tracker (burst_err).
module ahb_slave_mem
    import ahb_pkg::*;
#(
    parameter int              ADDR_W      = 32,
    parameter int              DATA_W      = 32,
    parameter int              MEM_WORDS   = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int              WAIT_CYCLES = 0
) (
    input  logic           CLK_SLAVE,
    input  logic           RESET_SLAVE,
    ahb_slave_mem_if.slave bus,
    output logic           burst_err
);
    localparam int                IDX_W     = $clog2(MEM_WORDS);
    localparam logic [ADDR_W-1:0] SPAN      = ADDR_W'(4 * MEM_WORDS);
    localparam logic [2:0]        WAIT_LOAD = 3'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    slv_state_e        state_q, state_d, accept_state;
    logic [2:0]        wait_cnt_q;
    logic [IDX_W-1:0]  lat_idx_q;
    logic [1:0]        lat_lane_q;
    logic [2:0]        lat_size_q;
    logic              lat_write_q;
    logic [DATA_W-1:0] hrdata_q, rd_word;
    logic [ADDR_W-1:0] offset;
    logic              hready, hresp, accept, addr_err, wr_en, rd_phase;
    logic [3:0]        be;

    // BASE_ADDR is word aligned, so offset[1:0] equals the byte lane of HADDR.
    assign offset   = bus.HADDR - BASE_ADDR;
    assign accept   = bus.HSEL && bus.HTRANS[1] && hready;
    assign addr_err = (offset >= SPAN) || (bus.HSIZE > HSIZE_WORD)
                   || ((bus.HSIZE == HSIZE_HALF) && offset[0])
                   || ((bus.HSIZE == HSIZE_WORD) && (offset[1:0] != 2'b00));

    // Errors bypass the wait states entirely.
    always_comb begin
        accept_state = SLV_DATA;
        if (addr_err)              accept_state = SLV_ERR1;
        else if (WAIT_CYCLES != 0) accept_state = SLV_WAIT;
    end

    always_ff @(posedge CLK_SLAVE or negedge RESET_SLAVE) begin
        if (!RESET_SLAVE) state_q <= SLV_IDLE;
        else              state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SLV_IDLE, SLV_DATA, SLV_ERR2: state_d = accept ? accept_state : SLV_IDLE;
            SLV_WAIT:                     if (wait_cnt_q == 3'd0) state_d = SLV_DATA;
            SLV_ERR1:                     state_d = SLV_ERR2;
            default:                      state_d = SLV_IDLE;
        endcase
    end

    always_comb begin
        hready = 1'b1;
        hresp  = HRESP_OKAY;
        case (state_q)
            SLV_WAIT: hready = 1'b0;
            SLV_ERR1: begin
                hready = 1'b0;
                hresp  = HRESP_ERROR;
            end
            SLV_ERR2: hresp = HRESP_ERROR;
            default: ;
        endcase
    end

    assign wr_en    = (state_q == SLV_DATA) && lat_write_q;
    assign rd_phase = (state_q == SLV_DATA) && !lat_write_q;
    assign be       = byte_en(lat_size_q, lat_lane_q);

    always_ff @(posedge CLK_SLAVE or negedge RESET_SLAVE) begin
        if (!RESET_SLAVE) begin
            wait_cnt_q  <= '0;
            lat_idx_q   <= '0;
            lat_lane_q  <= '0;
            lat_size_q  <= '0;
            lat_write_q <= 1'b0;
            hrdata_q    <= '0;
        end else begin
            if (accept) begin
                lat_idx_q   <= offset[IDX_W+1:2];
                lat_lane_q  <= offset[1:0];
                lat_size_q  <= bus.HSIZE;
                lat_write_q <= bus.HWRITE;
                wait_cnt_q  <= WAIT_LOAD;
            end else if ((state_q == SLV_WAIT) && (wait_cnt_q != 3'd0)) begin
                wait_cnt_q <= wait_cnt_q - 3'd1;
            end
            // Capture the word so HRDATA holds it outside read data phases.
            if (rd_phase) hrdata_q <= rd_word;
        end
    end

    ahb_slave_bytemem #(
        .WORDS  (MEM_WORDS),
        .DATA_W (DATA_W)
    ) u_mem (
        .CLK_SLAVE (CLK_SLAVE),
        .wr_en     (wr_en),
        .idx       (lat_idx_q),
        .be        (be),
        .wr_dat    (bus.HWDATA),
        .rd_dat    (rd_word)
    );

    assign bus.HREADY = hready;
    assign bus.HRESP  = hresp;
    assign bus.HRDATA = rd_phase ? rd_word : hrdata_q;

`ifdef AHB_SLV_BURST_CHECK_EN
    logic [ADDR_W-1:0] exp_addr_q, step, wrap_mask, next_addr;
    logic              trk_vld_q, burst_err_q;

    assign step      = ADDR_W'(1) << bus.HSIZE;
    assign wrap_mask = (step << 2) - ADDR_W'(1);
    assign next_addr = (bus.HBURST == HBURST_WRAP4)
                     ? ((bus.HADDR & ~wrap_mask) | ((bus.HADDR + step) & wrap_mask))
                     : (bus.HADDR + step);

    // BUSY keeps the burst open; an IDLE or deselect closes it.
    always_ff @(posedge CLK_SLAVE or negedge RESET_SLAVE) begin
        if (!RESET_SLAVE) begin
            exp_addr_q  <= '0;
            trk_vld_q   <= 1'b0;
            burst_err_q <= 1'b0;
        end else if (accept) begin
            if ((bus.HTRANS == HTRANS_SEQ) && (!trk_vld_q || (bus.HADDR != exp_addr_q)))
                burst_err_q <= 1'b1;
            exp_addr_q <= next_addr;
            trk_vld_q  <= 1'b1;
        end else if (hready && (!bus.HSEL || (bus.HTRANS == HTRANS_IDLE))) begin
            trk_vld_q <= 1'b0;
        end
    end

    assign burst_err = burst_err_q;
`else
    assign burst_err = 1'b0;
`endif
endmodule

// File: tb/tb_ahb_slave_mem.sv
module tb_ahb_slave_mem;
    import ahb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hsel = 1'b0;
    bit          dsel = 1'b0;
    logic [31:0] haddr = '0;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'd2;
    logic [2:0]  hburst = 3'd0;
    logic [1:0]  htrans = 2'd0;
    logic [31:0] hwdata = '0;
    logic        burst_err0, burst_err1;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    ahb_slave_mem_if bus0 ();
    ahb_slave_mem_if bus1 ();

    assign bus0.HSEL = hsel && !dsel;    assign bus1.HSEL = hsel && dsel;
    assign bus0.HADDR = haddr;           assign bus1.HADDR = haddr;
    assign bus0.HWRITE = hwrite;         assign bus1.HWRITE = hwrite;
    assign bus0.HSIZE = hsize;           assign bus1.HSIZE = hsize;
    assign bus0.HBURST = hburst;         assign bus1.HBURST = hburst;
    assign bus0.HTRANS = htrans;         assign bus1.HTRANS = htrans;
    assign bus0.HWDATA = hwdata;         assign bus1.HWDATA = hwdata;

    ahb_slave_mem #(.WAIT_CYCLES(0)) u_dut0 (
        .CLK_SLAVE(clk), .RESET_SLAVE(rst_n), .bus(bus0), .burst_err(burst_err0));
    ahb_slave_mem #(.WAIT_CYCLES(2)) u_dut1 (
        .CLK_SLAVE(clk), .RESET_SLAVE(rst_n), .bus(bus1), .burst_err(burst_err1));

    typedef struct {
        bit          d;
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [1:0]  trans;
        logic [2:0]  burst;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_waits;
    } vec_t;

    typedef struct {
        bit          d;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_waits;
    } sb_t;

    typedef struct {
        bit          d;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] raddr;
        logic [31:0] rexp;
        int          rwaits;
    } err_t;

    vec_t vt[$];
    sb_t  sbq[$];
    err_t et[$];

    function automatic logic rdy(input bit g);
        return g ? bus1.HREADY : bus0.HREADY;
    endfunction
    function automatic logic resp(input bit g);
        return g ? bus1.HRESP : bus0.HRESP;
    endfunction
    function automatic logic [31:0] rdata(input bit g);
        return g ? bus1.HRDATA : bus0.HRDATA;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic add(input bit d, input logic [31:0] a, input logic wr, input logic [2:0] sz,
                       input logic [1:0] tr, input logic [2:0] bu, input logic [31:0] wd,
                       input logic [31:0] ex, input int w);
        vec_t v;
        v.d = d; v.addr = a; v.wr = wr; v.size = sz; v.trans = tr; v.burst = bu;
        v.wdata = wd; v.exp_rdata = ex; v.exp_waits = w;
        vt.push_back(v);
    endtask

    // Pipelined master: row k's address phase overlaps row k-1's data phase.
    task automatic run_table(input int lo, input int hi);
        sb_t e;
        int  waits;
        bit  g;
        for (int k = lo; k <= hi; k++) begin
            if (k < hi) begin
                dsel = vt[k].d; hsel = 1'b1; haddr = vt[k].addr; hwrite = vt[k].wr;
                hsize = vt[k].size; htrans = vt[k].trans; hburst = vt[k].burst;
            end else begin
                hsel = 1'b0; htrans = HTRANS_IDLE;
            end
            hwdata = (sbq.size() != 0) ? sbq[0].wdata : 32'h0;
            g = (sbq.size() != 0) ? sbq[0].d : dsel;
            waits = 0;
            @(negedge clk);
            while (!rdy(g) && waits < 20) begin
                waits++;
                @(negedge clk);
            end
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk($sformatf("row%0d_waits", k - 1), 32'(waits), 32'(e.exp_waits));
                chk($sformatf("row%0d_hresp", k - 1), 32'(resp(g)), 32'd0);
                if (!e.wr) chk($sformatf("row%0d_hrdata", k - 1), rdata(g), e.exp_rdata);
            end
            if (k < hi && vt[k].trans[1]) begin
                e.d = vt[k].d; e.wr = vt[k].wr; e.wdata = vt[k].wdata;
                e.exp_rdata = vt[k].exp_rdata; e.exp_waits = vt[k].exp_waits;
                sbq.push_back(e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic err_seq(input err_t x);
        int waits;
        dsel = x.d; hsel = 1'b1; haddr = x.addr; hsize = x.size; hwrite = 1'b1;
        htrans = HTRANS_NONSEQ; hburst = HBURST_SINGLE;
        @(negedge clk);
        chk("err_accept_hready", 32'(rdy(x.d)), 32'd1);
        @(posedge clk); #1;
        htrans = HTRANS_IDLE; hwdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("err1_hready", 32'(rdy(x.d)), 32'd0);
        chk("err1_hresp", 32'(resp(x.d)), 32'd1);
        @(posedge clk); #1;
        haddr = x.raddr; hsize = 3'd2; hwrite = 1'b0; htrans = HTRANS_NONSEQ;
        @(negedge clk);
        chk("err2_hready", 32'(rdy(x.d)), 32'd1);
        chk("err2_hresp", 32'(resp(x.d)), 32'd1);
        @(posedge clk); #1;
        htrans = HTRANS_IDLE; hsel = 1'b0;
        waits = 0;
        @(negedge clk);
        while (!rdy(x.d) && waits < 20) begin
            waits++;
            @(negedge clk);
        end
        chk("err_rd_waits", 32'(waits), 32'(x.rwaits));
        chk("err_rd_hresp", 32'(resp(x.d)), 32'd0);
        chk("err_rd_hrdata", rdata(x.d), x.rexp);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int   n_main;
        err_t x;
        logic exp_berr;

        // d, addr, wr, size, trans, burst, wdata, exp_rdata, exp_waits
        add(0, 32'h00, 1, 3'd2, HTRANS_NONSEQ, HBURST_SINGLE, 32'hC0FF_EE00, 32'h0, 0);
        add(0, 32'h08, 1, 3'd2, HTRANS_NONSEQ, HBURST_SINGLE, 32'hDEAD_BEEF, 32'h0, 0);
        add(0, 32'h08, 0, 3'd2, HTRANS_NONSEQ, HBURST_SINGLE, 32'h0, 32'hDEAD_BEEF, 0);
        add(0, 32'h20, 1, 3'd2, HTRANS_NONSEQ, HBURST_SINGLE, 32'h0000_0000, 32'h0, 0);
        add(0, 32'h21, 1, 3'd0, HTRANS_NONSEQ, HBURST_SINGLE, 32'h1234_AB78, 32'h0, 0);
        add(0, 32'h20, 0, 3'd2, HTRANS_NONSEQ, HBURST_SINGLE, 32'h0, 32'h0000_AB00, 0);
        add(0, 32'h22, 1, 3'd1, HTRANS_NONSEQ, HBURST_SINGLE, 32'hBEEF_5678, 32'h0, 0);
        add(0, 32'h20, 0, 3'd2, HTRANS_NONSEQ, HBURST_SINGLE, 32'h0, 32'hBEEF_AB00, 0);
        add(0, 32'hFC, 1, 3'd2, HTRANS_NONSEQ, HBURST_SINGLE, 32'h0BAD_F00D, 32'h0, 0);
        add(0, 32'hFC, 0, 3'd2, HTRANS_NONSEQ, HBURST_SINGLE, 32'h0, 32'h0BAD_F00D, 0);
        add(1, 32'h00, 0, 3'd2, HTRANS_IDLE,   HBURST_SINGLE, 32'h0, 32'h0, 0);
        for (int i = 0; i < 4; i++)
            add(1, 32'h10 + 32'(4 * i), 1, 3'd2, (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ,
                HBURST_INCR4, 32'h11 * 32'(i + 1), 32'h0, 2);
        for (int i = 0; i < 4; i++)
            add(1, 32'h10 + 32'(4 * i), 0, 3'd2, (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ,
                HBURST_INCR4, 32'h0, 32'h11 * 32'(i + 1), 2);
        add(1, 32'h1C, 1, 3'd2, HTRANS_NONSEQ, HBURST_WRAP4, 32'hAAAA_0001, 32'h0, 2);
        add(1, 32'h10, 1, 3'd2, HTRANS_SEQ,    HBURST_WRAP4, 32'hBBBB_0002, 32'h0, 2);
        add(1, 32'h14, 1, 3'd2, HTRANS_SEQ,    HBURST_WRAP4, 32'hCCCC_0003, 32'h0, 2);
        add(1, 32'h18, 1, 3'd2, HTRANS_SEQ,    HBURST_WRAP4, 32'hDDDD_0004, 32'h0, 2);
        add(1, 32'h10, 0, 3'd2, HTRANS_NONSEQ, HBURST_SINGLE, 32'h0, 32'hBBBB_0002, 2);
        add(1, 32'h1C, 0, 3'd2, HTRANS_NONSEQ, HBURST_SINGLE, 32'h0, 32'hAAAA_0001, 2);
        add(1, 32'h14, 0, 3'd2, HTRANS_NONSEQ, HBURST_SINGLE, 32'h0, 32'hCCCC_0003, 2);
        add(1, 32'h18, 0, 3'd2, HTRANS_NONSEQ, HBURST_SINGLE, 32'h0, 32'hDDDD_0004, 2);
        add(1, 32'h30, 1, 3'd2, HTRANS_NONSEQ, HBURST_SINGLE, 32'h5555_AAAA, 32'h0, 2);
        n_main = vt.size();
        add(1, 32'h30, 0, 3'd2, HTRANS_NONSEQ, HBURST_SINGLE, 32'h0, 32'h5555_AAAA, 2);

        // d, addr, size, read-back addr, read-back data, read-back waits
        x = '{0, 32'h100, 3'd2, 32'h00, 32'hC0FF_EE00, 0}; et.push_back(x);
        x = '{0, 32'h001, 3'd1, 32'h00, 32'hC0FF_EE00, 0}; et.push_back(x);
        x = '{0, 32'h000, 3'd3, 32'h00, 32'hC0FF_EE00, 0}; et.push_back(x);
        x = '{0, 32'h002, 3'd2, 32'h00, 32'hC0FF_EE00, 0}; et.push_back(x);
        x = '{1, 32'h100, 3'd2, 32'h10, 32'hBBBB_0002, 2}; et.push_back(x);

        #2;
        chk("rst_hready0", 32'(bus0.HREADY), 32'd1);
        chk("rst_hresp0",  32'(bus0.HRESP),  32'd0);
        chk("rst_hrdata0", bus0.HRDATA,      32'd0);
        chk("rst_hready1", 32'(bus1.HREADY), 32'd1);
        chk("rst_berr0",   32'(burst_err0),  32'd0);
        #20;
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_table(0, n_main);
        chk("wrap_berr1", 32'(burst_err1), 32'd0);

        // SEQ that skips a beat: 0x10 then 0x18.
        dsel = 1'b0; hsel = 1'b1; haddr = 32'h10; hwrite = 1'b0; hsize = 3'd2;
        htrans = HTRANS_NONSEQ; hburst = HBURST_INCR4;
        @(posedge clk); #1;
        haddr = 32'h18; htrans = HTRANS_SEQ;
        @(posedge clk); #1;
        htrans = HTRANS_IDLE; hsel = 1'b0;
        @(posedge clk); #1;
`ifdef AHB_SLV_BURST_CHECK_EN
        exp_berr = 1'b1;
`else
        exp_berr = 1'b0;
`endif
        @(negedge clk);
        chk("seq_skip_berr0", 32'(burst_err0), 32'(exp_berr));
        @(posedge clk); #1;

        foreach (et[i]) err_seq(et[i]);

        chk("hrdata_hold0", bus0.HRDATA, 32'hC0FF_EE00);

        // Reset during the wait states of a write: the write must be lost.
        dsel = 1'b1; hsel = 1'b1; haddr = 32'h30; hwrite = 1'b1; hsize = 3'd2;
        htrans = HTRANS_NONSEQ; hburst = HBURST_SINGLE;
        @(posedge clk); #1;
        htrans = HTRANS_IDLE; hwdata = 32'h1234_5678;
        @(negedge clk);
        chk("drop_in_wait", 32'(bus1.HREADY), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("async_hready1", 32'(bus1.HREADY), 32'd1);
        chk("async_hresp1",  32'(bus1.HRESP),  32'd0);
        chk("async_hrdata0", bus0.HRDATA,      32'd0);
        chk("async_hrdata1", bus1.HRDATA,      32'd0);
        chk("async_berr0",   32'(burst_err0),  32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        hsel = 1'b0;
        @(posedge clk); #1;

        run_table(n_main, n_main + 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
